// File: rtl/uart_tx_feeder.sv
// Byte FIFO that drains into a UART controller register port, writing the TX data
// register only after a status poll reports the transmitter idle.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          enable,
  input  logic          flush,
  output logic [AW:0]   count,
  output logic          idle,
  output logic [3:0]    ctl_addr,
  output logic [31:0]   ctl_wdata,
  output logic          ctl_we,
  output logic          ctl_re,
  input  logic [31:0]   ctl_rdata
);

  localparam logic [AW:0] FULL_COUNT  = (AW+1)'(DEPTH);
  localparam logic [3:0]  ADDR_DATA   = 4'h0;
  localparam logic [3:0]  ADDR_STATUS = 4'h8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POLL,
    S_WAIT,
    S_WRITE
  } state_t;

  state_t          state_reg;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;
  logic            push;
  logic            pop;
  logic [3:0]      ctl_addr_reg;
  logic [31:0]     ctl_wdata_reg;
  logic            ctl_we_reg;
  logic            ctl_re_reg;
  logic            rdata_unused;

  // Only the busy flag of the status word matters here.
  assign rdata_unused = ^ctl_rdata[31:1];

  // in_ready depends on the occupancy register alone, never on this cycle's pop.
  assign in_ready = (count_reg != FULL_COUNT);
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (state_reg == S_WRITE) && !flush;

  always_comb begin
    count_next = count_reg;
    unique case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_next;
    end
  end

  // Strobes and address are registered alongside the state so they reflect the
  // state being entered; head byte is captured on the way into WRITE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      ctl_addr_reg  <= '0;
      ctl_wdata_reg <= '0;
      ctl_we_reg    <= 1'b0;
      ctl_re_reg    <= 1'b0;
    end else begin
      ctl_addr_reg  <= '0;
      ctl_wdata_reg <= '0;
      ctl_we_reg    <= 1'b0;
      ctl_re_reg    <= 1'b0;
      if (flush) begin
        state_reg <= S_IDLE;
      end else begin
        unique case (state_reg)
          S_IDLE: begin
            if (enable && (count_reg != '0)) begin
              state_reg    <= S_POLL;
              ctl_re_reg   <= 1'b1;
              ctl_addr_reg <= ADDR_STATUS;
            end
          end
          S_POLL: begin
            state_reg    <= S_WAIT;
            ctl_addr_reg <= ADDR_STATUS;
          end
          S_WAIT: begin
            if (!enable) begin
              state_reg <= S_IDLE;
            end else if (ctl_rdata[0]) begin
              state_reg    <= S_POLL;
              ctl_re_reg   <= 1'b1;
              ctl_addr_reg <= ADDR_STATUS;
            end else begin
              state_reg     <= S_WRITE;
              ctl_we_reg    <= 1'b1;
              ctl_addr_reg  <= ADDR_DATA;
              ctl_wdata_reg <= {24'h0, mem[rd_ptr_reg]};
            end
          end
          S_WRITE: begin
            state_reg <= S_IDLE;
          end
          default: begin
            state_reg <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign count     = count_reg;
  assign idle      = (state_reg == S_IDLE) && (count_reg == '0);
  assign ctl_addr  = ctl_addr_reg;
  assign ctl_wdata = ctl_wdata_reg;
  assign ctl_we    = ctl_we_reg;
  assign ctl_re    = ctl_re_reg;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a small UART controller model that
// answers status polls and serialises written bytes.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          enable;
  logic          flush;
  logic [AW:0]   count;
  logic          idle;
  logic [3:0]    ctl_addr;
  logic [31:0]   ctl_wdata;
  logic          ctl_we;
  logic          ctl_re;
  logic [31:0]   ctl_rdata = 32'h0;

  // controller model state
  logic          tx_busy = 1'b0;
  logic [9:0]    tx_shift = 10'h3FF;
  int            tx_bits = 0;
  int            tx_baud = 0;
  int            baud_div = 868;
  logic          tx_line;
  logic [7:0]    wr_log[$];
  int            wr_while_busy = 0;
  int            strobe_clash = 0;
  int            re_bad_addr = 0;
  int            we_bad_addr = 0;
  int            wdata_stray = 0;

  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .enable    (enable),
    .flush     (flush),
    .count     (count),
    .idle      (idle),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_we    (ctl_we),
    .ctl_re    (ctl_re),
    .ctl_rdata (ctl_rdata)
  );

  assign tx_line = tx_busy ? tx_shift[0] : 1'b1;

  always @(posedge clk) begin
    if (ctl_re) ctl_rdata <= {31'h0, tx_busy};
    if (ctl_we && ctl_re) strobe_clash <= strobe_clash + 1;
    if (ctl_re && ctl_addr != 4'h8) re_bad_addr <= re_bad_addr + 1;
    if (ctl_we && ctl_addr != 4'h0) we_bad_addr <= we_bad_addr + 1;
    if (!ctl_we && ctl_wdata != 32'h0) wdata_stray <= wdata_stray + 1;
    if (ctl_we) begin
      if (tx_busy) wr_while_busy <= wr_while_busy + 1;
      wr_log.push_back(ctl_wdata[7:0]);
      $display("ctl write: data=%02h busy=%0d t=%0t", ctl_wdata[7:0], tx_busy, $time);
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, ctl_wdata[7:0], 1'b0};
      tx_bits  <= 10;
      tx_baud  <= baud_div - 1;
    end else if (tx_busy) begin
      if (tx_baud == 0) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_baud  <= baud_div - 1;
        tx_bits  <= tx_bits - 1;
        if (tx_bits == 1) tx_busy <= 1'b0;
      end else begin
        tx_baud <= tx_baud - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < wr_log.size()) return {24'h0, wr_log[i]};
    return 32'hDEAD;
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int cyc = 0;
    logic done;
    done = 1'b0;
    while (!done && cyc < budget) begin
      @(posedge clk);
      #1;
      cyc++;
      done = (wr_log.size() >= n) && idle && !tx_busy;
    end
    check(tag, {31'h0, done}, 32'h1);
  endtask

  task automatic wait_we(input string tag, input int budget);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!ctl_we && cyc < budget);
    check(tag, {31'h0, ctl_we}, 32'h1);
  endtask

  initial begin
    int lat;
    int re_at;
    int acc;
    logic rdy;
    logic [9:0] frame;
    logic [7:0] base;

    rst_n    = 1'b1;
    in_data  = 8'h0;
    in_valid = 1'b0;
    enable   = 1'b0;
    flush    = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);
    check("rst_idle", {31'h0, idle}, 32'h1);
    check("rst_count", {27'h0, count}, 32'h0);
    check("rst_strobes", {30'h0, ctl_we, ctl_re}, 32'h0);
    check("rst_addr", {28'h0, ctl_addr}, 32'h0);
    check("rst_wdata", ctl_wdata, 32'h0);

    // single byte, real baud divisor, verify latency and serial frame
    baud_div = 868;
    enable = 1'b1;
    push_byte(8'hA5);
    lat = 0;
    re_at = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (ctl_re && re_at == 0) re_at = lat;
      if (ctl_we) break;
    end
    check("single_latency", lat, 3);
    check("single_re_cycle", re_at, 1);
    check("single_wdata", ctl_wdata, 32'h000000A5);
    check("single_addr", {28'h0, ctl_addr}, 32'h0);
    @(posedge clk);
    repeat (baud_div / 2) @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      frame[k] = tx_line;
      repeat (baud_div) @(posedge clk);
      #1;
    end
    check("single_frame", {22'h0, frame}, 32'h34A);
    wait_writes("single_drain", 1, 12000);
    check("single_count", wr_log.size(), 1);

    // three back-to-back bytes
    baud_div = 4;
    wr_log.delete();
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    wait_writes("burst_drain", 3, 2000);
    check("burst_n", wr_log.size(), 3);
    check("burst_0", log_at(0), 32'h11);
    check("burst_1", log_at(1), 32'h22);
    check("burst_2", log_at(2), 32'h33);

    // two full fills with enable low, then drain; pointers wrap
    for (int f = 0; f < 2; f++) begin
      base = (f == 0) ? 8'h40 : 8'h80;
      enable = 1'b0;
      wr_log.delete();
      acc = 0;
      for (int i = 0; i < DEPTH + 2; i++) begin
        @(negedge clk);
        in_data  = 8'(base + i);
        in_valid = 1'b1;
        rdy = in_ready;
        @(posedge clk);
        if (rdy) acc++;
      end
      #1;
      in_valid = 1'b0;
      check("fill_accepts", acc, DEPTH);
      check("fill_count", {27'h0, count}, DEPTH);
      check("fill_ready", {31'h0, in_ready}, 32'h0);
      check("fill_nowrite", wr_log.size(), 0);
      @(negedge clk);
      enable = 1'b1;
      wait_writes("fill_drain", DEPTH, 4000);
      for (int i = 0; i < DEPTH; i++) begin
        check("fill_order", log_at(i), {24'h0, 8'(base + i)});
      end
    end

    // push and pop on the same edge at count=5
    enable = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 5; i++) push_byte(8'(8'h50 + i));
    check("pp_pre_count", {27'h0, count}, 32'h5);
    @(negedge clk);
    enable = 1'b1;
    wait_we("pp_we_seen", 50);
    in_data  = 8'h55;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("pp_count", {27'h0, count}, 32'h5);
    wait_writes("pp_drain", 6, 2000);
    for (int i = 0; i < 6; i++) begin
      check("pp_order", log_at(i), {24'h0, 8'(8'h50 + i)});
    end

    // flush with count=7 while the FSM sits in WAIT
    enable = 1'b0;
    wr_log.delete();
    for (int i = 0; i < 7; i++) push_byte(8'(8'h60 + i));
    check("fl_pre_count", {27'h0, count}, 32'h7);
    @(negedge clk);
    enable = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ctl_re && lat < 20);
    check("fl_poll_seen", {31'h0, ctl_re}, 32'h1);
    @(negedge clk);
    check("fl_wait_addr", {27'h0, ctl_re, ctl_addr}, 32'h8);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("fl_count", {27'h0, count}, 32'h0);
    check("fl_idle", {31'h0, idle}, 32'h1);
    check("fl_we", {31'h0, ctl_we}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("fl_nowrite", wr_log.size(), 0);

    // flush and push together: the byte is discarded
    @(negedge clk);
    in_data  = 8'h99;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flpush_count", {27'h0, count}, 32'h0);
    check("flpush_idle", {31'h0, idle}, 32'h1);
    repeat (20) @(posedge clk);
    #1;
    check("flpush_nowrite", wr_log.size(), 0);

    // reset while ctl_we is high
    push_byte(8'h77);
    wait_we("rst_we_seen", 50);
    #1;
    rst_n = 1'b0;
    #1;
    check("rstw_we", {31'h0, ctl_we}, 32'h0);
    check("rstw_wdata", ctl_wdata, 32'h0);
    check("rstw_count", {27'h0, count}, 32'h0);
    check("rstw_idle", {30'h0, idle, in_ready}, 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rstw_nowrite", wr_log.size(), 0);

    check("no_write_while_busy", wr_while_busy, 0);
    check("no_strobe_clash", strobe_clash, 0);
    check("re_addr", re_bad_addr, 0);
    check("we_addr", we_bad_addr, 0);
    check("wdata_outside_write", wdata_stray, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Buffers outgoing bytes from a streaming producer (DMA engine, debug console, CPU store path) in a FIFO. Drains them one at a time into the UART controller's register port. It sits directly upstream of the UART controller and is the only master of that port while enabled. It polls the status register (0x8, bit 0 = TX busy) and writes the TX data register (0x0) only when the transmitter is idle, so no byte is ever overwritten mid-frame.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- in_data  in  8  byte from producer
- in_valid  in  1  producer offers in_data
- in_ready  out  1  FIFO can accept; a transfer occurs when in_valid && in_ready at a rising edge
- enable  in  1  when 0, FSM does not leave IDLE; FIFO still accepts bytes
- flush  in  1  synchronous clear of FIFO contents
- count  out  AW+1  current FIFO occupancy
- idle  out  1  FSM in IDLE and FIFO empty
- ctl_addr  out  4  UART controller register address
- ctl_wdata  out  32  UART controller write data
- ctl_we  out  1  UART controller write strobe
- ctl_re  out  1  UART controller read strobe
- ctl_rdata  in  32  UART controller read data, registered: valid the cycle after ctl_re

## Operation
- FIFO: circular buffer, DEPTH×8, read/write pointers AW bits wide that wrap modulo DEPTH. count is a separate AW+1-bit register.
- in_ready = (count != DEPTH); combinational from count only, never from the pop.
- Push when full is impossible, because in_ready=0. Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
- flush has priority over push and pop in the same cycle: pointers and count go to 0, and the FSM returns to IDLE at the next edge.
- FSM states (Moore; ctl_* decoded from state and FIFO head):
  - IDLE: all strobes 0. Go to POLL if enable && count!=0 && !flush.
  - POLL: ctl_re=1, ctl_addr=4'h8. Always go to WAIT.
  - WAIT: strobes 0, ctl_addr=4'h8. Sample ctl_rdata[0]. If 1 (busy), go to POLL. If 0, go to WRITE.
  - WRITE: ctl_we=1, ctl_addr=4'h0, ctl_wdata={24'h0, head byte}. Pop at the edge and go to IDLE.
- ctl_wdata = 0 in every state except WRITE. ctl_addr = 0 in IDLE.
- enable dropping in POLL or WAIT: finish the current poll, then return to IDLE instead of WRITE. In WRITE, enable is ignored; the write completes.
- Controller tx_busy goes high at the WRITE edge, so the next POLL after a WRITE reads busy=1. No settle state is needed.
- idle = (state==IDLE) && (count==0).
- Reset (rst=0, asynchronous):
  - state=IDLE, pointers=0, count=0.
  - in_ready=1, idle=1.
  - ctl_we=0, ctl_re=0, ctl_addr=0, ctl_wdata=0.
  - FIFO storage is not reset.
- Reset mid-frame drops all buffered bytes. The controller handles its own reset.

## Timing
- Push at edge E0 into an empty FIFO, with enable=1 and controller idle:
  - E1: IDLE→POLL
  - cycle after E1: ctl_re=1
  - E2: →WAIT
  - E3: →WRITE
  - cycle after E3: ctl_we=1
  - E4: pop, →IDLE
- Minimum latency from push edge to ctl_we high is 3 cycles. Back-to-back bytes are limited by the controller's frame time, not by this block.
- While the controller is busy, the block polls every 2 cycles (POLL/WAIT alternate).
- count updates at the same edge as the push or pop. in_ready follows in the same cycle.
- ctl_we and ctl_re are never high together and are each high for exactly one cycle per visit.

## Test plan
- Reset: hold rst=0, then release → in_ready=1, idle=1, count=0, all ctl_* =0. Asserting rst mid-WRITE forces ctl_we=0 immediately.
- Single byte 0xA5 pushed with a model controller (BAUD_DIV=868) → POLL/WAIT, then ctl_we pulse with ctl_wdata=32'h000000A5, 3 cycles after the push; uart_tx shows the start bit, 0xA5 LSB-first, then the stop bit.
- Push 3 bytes 0x11,0x22,0x33 back-to-back → exactly 3 ctl_we pulses in order. Each pulse comes only after a WAIT that sampled busy=0, and no write lands while tx_busy=1.
- Fill: push DEPTH+2 bytes with enable=0 → in_ready drops after DEPTH accepts, count=DEPTH. Set enable=1 → the FIFO drains all DEPTH bytes; wrap-around order is preserved across two full fills.
- Simultaneous push and pop at count=5 → count stays 5, and the byte order is intact.
- flush asserted with count=7 and the FSM in WAIT → next cycle count=0, FSM in IDLE, no ctl_we issued. A flush in the same cycle as a push discards that byte.
